sprite_reg_writer: RTL and testbench

//  Avalon-MM write initiator that drives the sprite-position register file of the VGA sprite display.

---
 rtl/sprite_wr_pkg.sv | 32 +++
 rtl/sprite_wr_fifo.sv | 71 +++++++
 rtl/sprite_reg_writer.sv | 181 ++++++++++++++++++
 tb/tb_sprite_reg_writer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_wr_pkg.sv
// -----------------------------------------------------------------------------
// sprite_wr_pkg
// Shared types and constants for the sprite register writer.
//   state_t      : write-initiator FSM states (IDLE, WRITE)
//   DINO_X..GODZ_Y : register indices of the sprite-position register file,
//                  one x/y pair per sprite
//   is_sprite_reg: true when an index falls inside the populated register range
// -----------------------------------------------------------------------------
package sprite_wr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [8:0] DINO_X = 9'd0;
  localparam logic [8:0] DINO_Y = 9'd1;
  localparam logic [8:0] JUMP_X = 9'd2;
  localparam logic [8:0] JUMP_Y = 9'd3;
  localparam logic [8:0] DUCK_X = 9'd4;
  localparam logic [8:0] DUCK_Y = 9'd5;
  localparam logic [8:0] SCAC_X = 9'd6;
  localparam logic [8:0] SCAC_Y = 9'd7;
  localparam logic [8:0] GODZ_X = 9'd8;
  localparam logic [8:0] GODZ_Y = 9'd9;

  // Index lies within the implemented sprite x/y registers.
  function automatic logic is_sprite_reg(input logic [8:0] idx);
    return (idx <= GODZ_Y);
  endfunction

endpackage

// File: rtl/sprite_wr_fifo.sv
// -----------------------------------------------------------------------------
// sprite_wr_fifo
// Synchronous FIFO holding pending {address, data} register updates.
// Pointers carry one extra MSB so full and empty are told apart by the
// difference wptr - rptr, which is also the occupancy.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata : write wdata at the tail when push && !full
//   pop         : drop the head when pop && !empty
//   rdata       : current head entry (valid while !empty)
//   full, empty : occupancy flags
//   count       : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sprite_wr_fifo
  import sprite_wr_pkg::*;
#(
  parameter int W     = 41,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] PTR_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0] PTR_FULL = {1'b1, {PW{1'b0}}};

  logic [W-1:0] mem_r [DEPTH];
  logic [PW:0]  wptr_r;
  logic [PW:0]  rptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign count     = wptr_r - rptr_r;
  assign full      = (count == PTR_FULL);
  assign empty     = (count == PTR_ZERO);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rptr_r[PW-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r[PW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/sprite_reg_writer.sv
// -----------------------------------------------------------------------------
// sprite_reg_writer
// Avalon-MM write initiator feeding the sprite-position register file of the
// VGA sprite display. Game logic queues (address, data) updates; the block
// drains them as single-beat Avalon writes, honouring waitrequest, aborting a
// write that stalls for TIMEOUT cycles.
//
// Build option:
//   SPRITE_WR_VBLANK_GATE_EN : when defined, a new write starts only while
//   vblank=1 so sprites never move mid-frame; a write already issued still
//   completes or times out. When undefined, writes start whenever the queue
//   is non-empty. frame_pulse is produced in both builds.
//
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   upd_valid/ready/addr/data: update push interface (ready = !full)
//   vblank                   : clk-synchronous blanking level
//   avm_*                    : Avalon-MM master write port
//   fifo_count               : queue occupancy
//   ovf, tmo                 : sticky overflow / timeout-abort flags
//   clr_err                  : synchronous clear of ovf/tmo (a same-cycle set wins)
//   frame_pulse              : one-cycle pulse on the vblank rising edge
// -----------------------------------------------------------------------------
module sprite_reg_writer
  import sprite_wr_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [AW-1:0]            upd_addr,
  input  logic [DW-1:0]            upd_data,
  input  logic                     vblank,
  output logic [AW-1:0]            avm_address,
  output logic [DW-1:0]            avm_writedata,
  output logic                     avm_write,
  output logic                     avm_chipselect,
  input  logic                     avm_waitrequest,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  output logic                     tmo,
  input  logic                     clr_err,
  output logic                     frame_pulse
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TCNT_ONE  = {{(TW-1){1'b0}}, 1'b1};
  // The final stalled cycle is the one where the counter would reach TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_t              state_r;
  logic [TW-1:0]       tcnt_r;
  logic                vblank_q_r;
  logic [AW+DW-1:0]    head_s;
  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                pop_s;
  logic                accept_s;
  logic                abort_s;
  logic                permit_s;
  logic                ovf_set_s;

  assign upd_ready      = !full_s;
  assign push_s         = upd_valid && !full_s;
  assign avm_chipselect = avm_write;
  assign frame_pulse    = vblank && !vblank_q_r;

`ifdef SPRITE_WR_VBLANK_GATE_EN
  assign permit_s = vblank;
`else
  assign permit_s = 1'b1;
`endif

  sprite_wr_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata ({upd_addr, upd_data}),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  // Write completion decode: accepted, aborted on timeout, or still stalled.
  always_comb begin
    accept_s  = 1'b0;
    abort_s   = 1'b0;
    ovf_set_s = upd_valid && full_s;
    if (avm_write) begin
      accept_s = !avm_waitrequest;
      abort_s  = avm_waitrequest && (tcnt_r == TMO_LAST);
    end else begin
      accept_s = 1'b0;
      abort_s  = 1'b0;
    end
    // The head leaves the queue only once its write has finished either way.
    pop_s = accept_s || abort_s;
  end

  // Write FSM: load the head onto the bus, hold it through stalls, retire it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      avm_address   <= {AW{1'b0}};
      avm_writedata <= {DW{1'b0}};
      avm_write     <= 1'b0;
      tcnt_r        <= TCNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s && permit_s) begin
            avm_address   <= head_s[AW+DW-1:DW];
            avm_writedata <= head_s[DW-1:0];
            avm_write     <= 1'b1;
            tcnt_r        <= TCNT_ZERO;
            state_r       <= WRITE;
          end
        end
        WRITE: begin
          // Retiring through IDLE gives one idle bus cycle between writes and
          // lets the FIFO present its next head after the pop.
          if (accept_s || abort_s) begin
            avm_write <= 1'b0;
            tcnt_r    <= TCNT_ZERO;
            state_r   <= IDLE;
          end else if (avm_write) begin
            tcnt_r <= tcnt_r + TCNT_ONE;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          avm_write <= 1'b0;
          tcnt_r    <= TCNT_ZERO;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      tmo <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
      if (abort_s) begin
        tmo <= 1'b1;
      end else if (clr_err) begin
        tmo <= 1'b0;
      end
    end
  end

  // Previous vblank level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q_r <= 1'b0;
    end else begin
      vblank_q_r <= vblank;
    end
  end

endmodule

// File: tb/tb_sprite_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_sprite_reg_writer
// Self-checking bench for sprite_reg_writer: a table of single writes with
// varying stall lengths, plus hand-written sequences for back-to-back writes,
// overflow, timeout abort, vblank gating/frame pulse and reset mid-write.
// -----------------------------------------------------------------------------
module tb_sprite_reg_writer;

  localparam int DEPTH   = 16;
  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_data;
  logic          vblank;
  logic [AW-1:0] avm_address;
  logic [DW-1:0] avm_writedata;
  logic          avm_write;
  logic          avm_chipselect;
  logic          avm_waitrequest;
  logic [4:0]    fifo_count;
  logic          ovf;
  logic          tmo;
  logic          clr_err;
  logic          frame_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int            exp_high;   // cycles avm_write stays high
  } vec_t;
  vec_t vecs[5];

  sprite_reg_writer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_addr        (upd_addr),
    .upd_data        (upd_data),
    .vblank          (vblank),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_chipselect  (avm_chipselect),
    .avm_waitrequest (avm_waitrequest),
    .fifo_count      (fifo_count),
    .ovf             (ovf),
    .tmo             (tmo),
    .clr_err         (clr_err),
    .frame_pulse     (frame_pulse)
  );

  always #10 clk = ~clk;

  // Record every accepted Avalon write.
  always @(posedge clk) begin
    if (!reset && avm_write && !avm_waitrequest) begin
      wq.push_back('{avm_address, avm_writedata});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_data  = d;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fifo_count == 5'd0 && !avm_write) break;
      @(negedge clk);
    end
    chk("drain_done", {63'd0, (fifo_count == 5'd0 && !avm_write)}, 64'd1);
  endtask

  initial begin
    int hi;
    reset = 1'b1; upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
    vblank = 1'b0; avm_waitrequest = 1'b0; clr_err = 1'b0;

    // vectors: {addr, data, stall, exp_addr, exp_data, exp_high}
    vecs[0] = '{9'd0, 32'd100,        0, 9'd0, 32'd100,        1};
    vecs[1] = '{9'd4, 32'd77,         5, 9'd4, 32'd77,         6};
    vecs[2] = '{9'd9, 32'h1234_5678,  1, 9'd9, 32'h1234_5678,  2};
    vecs[3] = '{9'd2, 32'h0000_00FF,  2, 9'd2, 32'h0000_00FF,  3};
    vecs[4] = '{9'd7, 32'hDEAD_BEEF, 12, 9'd7, 32'hDEAD_BEEF, 13};

    repeat (2) @(negedge clk);
    // ---- reset state ----
    chk("rst_write", {63'd0, avm_write}, 64'd0);
    chk("rst_cs", {63'd0, avm_chipselect}, 64'd0);
    chk("rst_addr", {55'd0, avm_address}, 64'd0);
    chk("rst_data", {32'd0, avm_writedata}, 64'd0);
    chk("rst_ready", {63'd0, upd_ready}, 64'd1);
    chk("rst_count", {59'd0, fifo_count}, 64'd0);
    chk("rst_flags", {62'd0, ovf, tmo}, 64'd0);
    chk("rst_pulse", {63'd0, frame_pulse}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // enter blanking so both builds may start writes
    vblank = 1'b1;
    #1 chk("vb_pulse_hi", {63'd0, frame_pulse}, 64'd1);
    @(negedge clk);
    chk("vb_pulse_lo", {63'd0, frame_pulse}, 64'd0);

    // ---- T1: back-to-back pushes ----
    wq.delete();
    upd_valid = 1'b1; upd_addr = 9'd0; upd_data = 32'd100;
    @(negedge clk);
    chk("t1_lat_write", {63'd0, avm_write}, 64'd0);
    chk("t1_cnt1", {59'd0, fifo_count}, 64'd1);
    upd_addr = 9'd1; upd_data = 32'd50;
    @(negedge clk);
    upd_valid = 1'b0;
    chk("t1_w0_write", {62'd0, avm_write, avm_chipselect}, 64'd3);
    chk("t1_w0_addr", {55'd0, avm_address}, 64'd0);
    chk("t1_w0_data", {32'd0, avm_writedata}, 64'd100);
    chk("t1_cnt2", {59'd0, fifo_count}, 64'd2);
    @(negedge clk);
    chk("t1_gap", {63'd0, avm_write}, 64'd0);
    chk("t1_cnt_pop", {59'd0, fifo_count}, 64'd1);
    @(negedge clk);
    chk("t1_w1_write", {63'd0, avm_write}, 64'd1);
    chk("t1_w1_addr", {55'd0, avm_address}, 64'd1);
    chk("t1_w1_data", {32'd0, avm_writedata}, 64'd50);
    @(negedge clk);
    chk("t1_end_write", {63'd0, avm_write}, 64'd0);
    chk("t1_end_cnt", {59'd0, fifo_count}, 64'd0);
    chk("t1_nwrites", 64'(wq.size()), 64'd2);

    // ---- table: single writes with stalls (T2 is vecs[1]) ----
    wq.delete();
    for (int v = 0; v < 5; v++) begin
      avm_waitrequest = (vecs[v].stall != 0);
      push(vecs[v].addr, vecs[v].data);
      chk("tv_latency", {63'd0, avm_write}, 64'd0);
      @(negedge clk);
      hi = 0;
      for (int k = 0; k <= vecs[v].stall; k++) begin
        if (avm_write) hi++;
        chk("tv_addr", {55'd0, avm_address}, {55'd0, vecs[v].exp_addr});
        chk("tv_data", {32'd0, avm_writedata}, {32'd0, vecs[v].exp_data});
        chk("tv_cnt_hold", {59'd0, fifo_count}, 64'd1);
        if (k == vecs[v].stall) avm_waitrequest = 1'b0;
        @(negedge clk);
      end
      chk("tv_high_cycles", 64'(hi), 64'(vecs[v].exp_high));
      chk("tv_write_drop", {63'd0, avm_write}, 64'd0);
      chk("tv_cnt_after", {59'd0, fifo_count}, 64'd0);
      @(negedge clk);
    end
    chk("tv_nwrites", 64'(wq.size()), 64'd5);
    for (int v = 0; v < 5 && v < wq.size(); v++) begin
      chk("tv_seq_addr", {55'd0, wq[v].a}, {55'd0, vecs[v].exp_addr});
      chk("tv_seq_data", {32'd0, wq[v].d}, {32'd0, vecs[v].exp_data});
    end

    // ---- T3: overflow ----
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 16; i++) push(9'(i % 10), 32'(200 + i));
    chk("t3_ready0", {63'd0, upd_ready}, 64'd0);
    chk("t3_count16", {59'd0, fifo_count}, 64'd16);
    chk("t3_ovf_pre", {63'd0, ovf}, 64'd0);
    push(9'd5, 32'd999);
    chk("t3_ovf_set", {63'd0, ovf}, 64'd1);
    chk("t3_count_keep", {59'd0, fifo_count}, 64'd16);
    upd_valid = 1'b1; upd_addr = 9'd5; upd_data = 32'd999; clr_err = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    chk("t3_set_wins", {63'd0, ovf}, 64'd1);
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_ovf_clr", {63'd0, ovf}, 64'd0);
    wq.delete();
    avm_waitrequest = 1'b0;
    wait_idle_empty(100);
    chk("t3_nwrites", 64'(wq.size()), 64'd16);
    for (int i = 0; i < 16 && i < wq.size(); i++) begin
      chk("t3_data", {32'd0, wq[i].d}, 64'(200 + i));
      chk("t3_addr", {55'd0, wq[i].a}, 64'(i % 10));
    end

    // ---- T4: timeout ----
    wq.delete();
    avm_waitrequest = 1'b1;
    push(9'd2, 32'd7);
    push(9'd3, 32'd8);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (avm_write) hi++;
      else if (hi != 0) break;
      @(negedge clk);
    end
    chk("t4_stall_cycles", 64'(hi), 64'(TIMEOUT));
    chk("t4_tmo", {63'd0, tmo}, 64'd1);
    chk("t4_cnt_after", {59'd0, fifo_count}, 64'd1);
    @(negedge clk);
    chk("t4_next_write", {63'd0, avm_write}, 64'd1);
    chk("t4_next_addr", {55'd0, avm_address}, 64'd3);
    chk("t4_next_data", {32'd0, avm_writedata}, 64'd8);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("t4_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("t4_wdata", {32'd0, wq[0].d}, 64'd8);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_tmo_clr", {63'd0, tmo}, 64'd0);

    // ---- T5: vblank gating / frame pulse ----
    wq.delete();
    vblank = 1'b0;
    @(negedge clk);
    push(9'd6, 32'd11);
    push(9'd7, 32'd12);
    push(9'd8, 32'd13);
`ifdef SPRITE_WR_VBLANK_GATE_EN
    repeat (10) @(negedge clk);
    chk("t5_held_writes", 64'(wq.size()), 64'd0);
    chk("t5_held_cnt", {59'd0, fifo_count}, 64'd3);
    vblank = 1'b1; avm_waitrequest = 1'b1;
    #1 chk("t5_pulse_hi", {63'd0, frame_pulse}, 64'd1);
    @(negedge clk);
    chk("t5_pulse_lo", {63'd0, frame_pulse}, 64'd0);
    chk("t5_start", {63'd0, avm_write}, 64'd1);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_hold_mid", {63'd0, avm_write}, 64'd1);
    avm_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_one_done", 64'(wq.size()), 64'd1);
    chk("t5_rest_wait", {59'd0, fifo_count}, 64'd2);
    vblank = 1'b1;
    wait_idle_empty(50);
`else
    wait_idle_empty(50);
    vblank = 1'b1;
    #1 chk("t5_pulse_hi", {63'd0, frame_pulse}, 64'd1);
    @(negedge clk);
    chk("t5_pulse_lo", {63'd0, frame_pulse}, 64'd0);
`endif
    chk("t5_nwrites", 64'(wq.size()), 64'd3);
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      chk("t5_order", {32'd0, wq[i].d}, 64'(11 + i));
    end

    // ---- T6: reset during WRITE ----
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) push(9'(i), 32'(300 + i));
    chk("t6_inflight", {63'd0, avm_write}, 64'd1);
    chk("t6_cnt4", {59'd0, fifo_count}, 64'd4);
    reset = 1'b1;
    #1;
    chk("t6_write_async", {62'd0, avm_write, avm_chipselect}, 64'd0);
    chk("t6_cnt0", {59'd0, fifo_count}, 64'd0);
    chk("t6_ready", {63'd0, upd_ready}, 64'd1);
    @(negedge clk);
    wq.delete();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_writes", 64'(wq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
